// File: rtl/pause_flow_ctrl.sv
// rtl/pause_flow_ctrl.sv - TX XOFF/XON scheduler and RX pause-quanta timer for the 10G MAC
// Optional statistics counters are built only when PAUSE_FLOW_STATS_EN is defined.
module pause_flow_ctrl #(
  parameter int LEVEL_W        = 12,
  parameter int QUANTUM_CYCLES = 8
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic [LEVEL_W-1:0] rx_fifo_level,
  input  logic [LEVEL_W-1:0] cfg_xoff_thresh,
  input  logic [LEVEL_W-1:0] cfg_xon_thresh,
  input  logic [15:0]        cfg_min_hold,
  input  logic               cfg_tx_pause_enable,
  input  logic               cfg_rx_pause_enable,
  input  logic               sw_pause_req,
  input  logic               rx_pause_valid,
  input  logic [15:0]        rx_pause_quanta,
  output logic               tx_pause_send,
  output logic               rx_pause_active,
  output logic [15:0]        rx_pause_remaining,
  output logic               cfg_err,
  input  logic               stats_clr,
  output logic [31:0]        stat_xoff_events,
  output logic [31:0]        stat_rx_pause_frames
);

  localparam int SUB_W = $clog2(QUANTUM_CYCLES);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(QUANTUM_CYCLES - 1);

  typedef enum logic [1:0] {
    TX_XON,
    TX_HOLD,
    TX_ARMED
  } tx_state_e;

  logic [15:0]      q_cnt_q, q_cnt_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  tx_state_e        state_q, state_d;
  logic [15:0]      hold_q, hold_d;
  logic             send_q;
  logic             cfg_err_q;
  logic             xoff_cond, xon_cond;
  logic             xoff_evt, rx_accept;

  // A misconfigured threshold pair masks only the level-based XOFF term.
  assign xoff_cond = sw_pause_req || (!cfg_err_q && (rx_fifo_level >= cfg_xoff_thresh));
  assign xon_cond  = !sw_pause_req && (rx_fifo_level <= cfg_xon_thresh);
  assign rx_accept = rx_pause_valid && cfg_rx_pause_enable;

  always_comb begin
    q_cnt_d   = q_cnt_q;
    sub_cnt_d = sub_cnt_q;
    if (!cfg_rx_pause_enable) begin
      q_cnt_d   = '0;
      sub_cnt_d = '0;
    end else if (rx_pause_valid) begin
      q_cnt_d   = rx_pause_quanta;
      sub_cnt_d = '0;
    end else if (q_cnt_q != 16'd0) begin
      if (sub_cnt_q == SUB_MAX) begin
        sub_cnt_d = '0;
        q_cnt_d   = q_cnt_q - 16'd1;
      end else begin
        sub_cnt_d = sub_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    xoff_evt = 1'b0;
    case (state_q)
      TX_XON: begin
        if (cfg_tx_pause_enable && xoff_cond) begin
          state_d  = TX_HOLD;
          hold_d   = cfg_min_hold;
          xoff_evt = 1'b1;
        end
      end
      TX_HOLD: begin
        if (hold_q == 16'd0) state_d = TX_ARMED;
        else                 hold_d  = hold_q - 16'd1;
      end
      TX_ARMED: begin
        if (xon_cond) state_d = TX_XON;
      end
      default: state_d = TX_XON;
    endcase
    if (!cfg_tx_pause_enable) begin
      state_d  = TX_XON;
      xoff_evt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      q_cnt_q   <= '0;
      sub_cnt_q <= '0;
      state_q   <= TX_XON;
      hold_q    <= '0;
      send_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      q_cnt_q   <= q_cnt_d;
      sub_cnt_q <= sub_cnt_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      send_q    <= (state_d != TX_XON);
      cfg_err_q <= (cfg_xon_thresh >= cfg_xoff_thresh);
    end
  end

  assign tx_pause_send      = send_q;
  assign rx_pause_active    = (q_cnt_q != 16'd0);
  assign rx_pause_remaining = q_cnt_q;
  assign cfg_err            = cfg_err_q;

`ifdef PAUSE_FLOW_STATS_EN
  logic [31:0] xoff_cnt_q, rxf_cnt_q;

  // Saturating counters; a clear wins over a coincident increment.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      xoff_cnt_q <= '0;
      rxf_cnt_q  <= '0;
    end else if (stats_clr) begin
      xoff_cnt_q <= '0;
      rxf_cnt_q  <= '0;
    end else begin
      if (xoff_evt && (xoff_cnt_q != 32'hFFFF_FFFF)) xoff_cnt_q <= xoff_cnt_q + 32'd1;
      if (rx_accept && (rxf_cnt_q != 32'hFFFF_FFFF)) rxf_cnt_q <= rxf_cnt_q + 32'd1;
    end
  end

  assign stat_xoff_events     = xoff_cnt_q;
  assign stat_rx_pause_frames = rxf_cnt_q;
`else
  logic unused_stats;
  assign unused_stats         = stats_clr ^ xoff_evt ^ rx_accept;
  assign stat_xoff_events     = 32'd0;
  assign stat_rx_pause_frames = 32'd0;
`endif

endmodule

// File: tb/tb_pause_flow_ctrl.sv
// tb/tb_pause_flow_ctrl.sv - scoreboard bench for pause_flow_ctrl
module tb_pause_flow_ctrl;

`ifdef PAUSE_FLOW_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int ID_SEND = 0, ID_ACT = 1, ID_REM = 2, ID_ERR = 3, ID_XOFF = 4, ID_RXF = 5;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [11:0] rx_fifo_level, cfg_xoff_thresh, cfg_xon_thresh;
  logic [15:0] cfg_min_hold, rx_pause_quanta;
  logic        cfg_tx_pause_enable, cfg_rx_pause_enable, sw_pause_req, rx_pause_valid, stats_clr;
  logic        tx_pause_send, rx_pause_active, cfg_err;
  logic [15:0] rx_pause_remaining;
  logic [31:0] stat_xoff_events, stat_rx_pause_frames;

  pause_flow_ctrl #(.LEVEL_W(12), .QUANTUM_CYCLES(8)) dut (
    .clk                 (clk),
    .aresetn             (aresetn),
    .rx_fifo_level       (rx_fifo_level),
    .cfg_xoff_thresh     (cfg_xoff_thresh),
    .cfg_xon_thresh      (cfg_xon_thresh),
    .cfg_min_hold        (cfg_min_hold),
    .cfg_tx_pause_enable (cfg_tx_pause_enable),
    .cfg_rx_pause_enable (cfg_rx_pause_enable),
    .sw_pause_req        (sw_pause_req),
    .rx_pause_valid      (rx_pause_valid),
    .rx_pause_quanta     (rx_pause_quanta),
    .tx_pause_send       (tx_pause_send),
    .rx_pause_active     (rx_pause_active),
    .rx_pause_remaining  (rx_pause_remaining),
    .cfg_err             (cfg_err),
    .stats_clr           (stats_clr),
    .stat_xoff_events    (stat_xoff_events),
    .stat_rx_pause_frames(stat_rx_pause_frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int id);
    case (id)
      ID_SEND: return {31'd0, tx_pause_send};
      ID_ACT:  return {31'd0, rx_pause_active};
      ID_REM:  return {16'd0, rx_pause_remaining};
      ID_ERR:  return {31'd0, cfg_err};
      ID_XOFF: return stat_xoff_events;
      default: return stat_rx_pause_frames;
    endcase
  endfunction

  task automatic expect_at(input int c, input int id, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = c; e.id = id; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_range(input int c0, input int c1, input int id, input logic [31:0] v,
                              input string name);
    for (int c = c0; c <= c1; c++) expect_at(c, id, v, name);
  endtask

  task automatic expect_all_zero(input int c, input string name);
    for (int id = 0; id < 6; id++) expect_at(c, id, 32'd0, name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: sample away from the active edge and retire every entry due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_checks++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: entry for cycle %0d never sampled (now %0d)", sb[i].name, sb[i].cyc, cyc);
        end else if (sample(sb[i].id) !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %0h, expected %0h", sb[i].name, cyc,
                   sample(sb[i].id), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  int n, m, d, t, u, v, w;

  initial begin
    aresetn = 1'b1;
    rx_fifo_level = 12'd0; cfg_xoff_thresh = 12'd800; cfg_xon_thresh = 12'd200;
    cfg_min_hold = 16'd50; cfg_tx_pause_enable = 1'b0; cfg_rx_pause_enable = 1'b1;
    sw_pause_req = 1'b0; rx_pause_valid = 1'b0; rx_pause_quanta = 16'd0; stats_clr = 1'b0;
    #1 aresetn = 1'b0;
    expect_all_zero(1, "reset_state");
    expect_all_zero(2, "reset_state");
    step(3);
    aresetn = 1'b1;
    step(2);

    // RX quanta=3: active for exactly 24 cycles, remaining steps 3,2,1,0
    n = cyc;
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd3;
    expect_at(n, ID_ACT, 32'd0, "q3_active_pre");
    expect_range(n + 1, n + 24, ID_ACT, 32'd1, "q3_active");
    expect_at(n + 25, ID_ACT, 32'd0, "q3_active_end");
    expect_at(n + 1, ID_REM, 32'd3, "q3_rem3");
    expect_at(n + 8, ID_REM, 32'd3, "q3_rem3_last");
    expect_at(n + 9, ID_REM, 32'd2, "q3_rem2");
    expect_at(n + 17, ID_REM, 32'd1, "q3_rem1");
    expect_at(n + 24, ID_REM, 32'd1, "q3_rem1_last");
    expect_at(n + 25, ID_REM, 32'd0, "q3_rem0");
    expect_at(n + 1, ID_RXF, STATS ? 32'd1 : 32'd0, "q3_stat_rx");
    step(1);
    rx_pause_valid = 1'b0;
    step(30);

    // Reload mid-pause: quanta 100 then quanta 2 after 40 cycles
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
    expect_at(cyc, ID_RXF, 32'd0, "clr_stat_rx");
    n = cyc;
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd100;
    step(1);
    rx_pause_valid = 1'b0;
    step(39);
    expect_at(cyc, ID_REM, 32'd96, "q100_rem_at40");
    m = cyc;
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd2;
    expect_range(m + 1, m + 16, ID_ACT, 32'd1, "reload_active");
    expect_at(m + 17, ID_ACT, 32'd0, "reload_active_end");
    expect_at(m + 1, ID_REM, 32'd2, "reload_rem");
    expect_at(m + 1, ID_RXF, STATS ? 32'd2 : 32'd0, "reload_stat_rx");
    step(1);
    rx_pause_valid = 1'b0;
    step(20);

    // Disable clears timer next cycle; strobe while disabled is ignored and uncounted
    d = cyc;
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd4;
    step(1);
    rx_pause_valid = 1'b0;
    step(2);
    cfg_rx_pause_enable = 1'b0;
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd9;
    expect_at(d + 3, ID_ACT, 32'd1, "dis_active_pre");
    expect_at(d + 4, ID_ACT, 32'd0, "dis_active");
    expect_at(d + 4, ID_REM, 32'd0, "dis_rem");
    expect_at(d + 4, ID_RXF, STATS ? 32'd3 : 32'd0, "dis_stat_rx");
    step(1);
    rx_pause_valid = 1'b0; cfg_rx_pause_enable = 1'b1;
    step(2);

    // TX: crossing at 800 then drop to 100; hold 51 cycles, one ARMED cycle, then XON
    cfg_tx_pause_enable = 1'b1; rx_fifo_level = 12'd700;
    step(1);
    t = cyc;
    rx_fifo_level = 12'd800;
    expect_at(t, ID_SEND, 32'd0, "tx_send_pre");
    expect_range(t + 1, t + 52, ID_SEND, 32'd1, "tx_send_hold");
    expect_at(t + 53, ID_SEND, 32'd0, "tx_send_xon");
    expect_at(t + 56, ID_SEND, 32'd0, "tx_send_idle");
    expect_at(t + 1, ID_XOFF, STATS ? 32'd1 : 32'd0, "tx_stat_xoff");
    step(1);
    rx_fifo_level = 12'd100;
    step(56);

    // Misconfigured thresholds: level masked, software request still works
    u = cyc;
    cfg_xon_thresh = 12'd500; cfg_xoff_thresh = 12'd400;
    expect_at(u + 1, ID_ERR, 32'd1, "cfg_err");
    expect_range(u + 3, u + 6, ID_SEND, 32'd0, "cfg_err_masked");
    step(2);
    rx_fifo_level = 12'd1000;
    step(4);
    sw_pause_req = 1'b1;
    expect_at(u + 7, ID_SEND, 32'd1, "sw_xoff");
    expect_at(u + 7, ID_XOFF, STATS ? 32'd2 : 32'd0, "sw_stat_xoff");
    step(53);

    // In TX_ARMED: disable drops send next cycle
    v = cyc;
    cfg_tx_pause_enable = 1'b0;
    expect_at(v, ID_SEND, 32'd1, "armed_send");
    expect_at(v + 1, ID_SEND, 32'd0, "disable_drop");
    step(1);
    cfg_tx_pause_enable = 1'b1;
    rx_pause_valid = 1'b1; rx_pause_quanta = 16'd5;
    expect_at(v + 2, ID_SEND, 32'd1, "reenable_send");
    expect_at(v + 2, ID_ACT, 32'd1, "pre_reset_active");
    expect_at(v + 2, ID_XOFF, STATS ? 32'd3 : 32'd0, "reenable_stat_xoff");
    step(1);
    rx_pause_valid = 1'b0;
    step(2);

    // Asynchronous reset mid-pause: outputs clear before the next clock edge
    expect_all_zero(cyc, "async_reset");
    expect_all_zero(cyc + 1, "in_reset");
    aresetn = 1'b0;
    step(2);
    sw_pause_req = 1'b0; rx_fifo_level = 12'd0;
    cfg_xon_thresh = 12'd200; cfg_xoff_thresh = 12'd800;
    aresetn = 1'b1;
    step(2);

    // stats_clr coincident with an XOFF event: clear wins
    w = cyc;
    stats_clr = 1'b1; sw_pause_req = 1'b1;
    expect_at(w + 1, ID_XOFF, 32'd0, "clr_vs_xoff");
    expect_at(w + 1, ID_SEND, 32'd1, "clr_xoff_send");
    step(1);
    stats_clr = 1'b0; sw_pause_req = 1'b0;
    step(5);

    for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for cycle %0d", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pause_flow_ctrl.md
Name: pause_flow_ctrl

Overview:
Flow-control scheduler for the 10G MAC TX/RX pause path. It drives the `tx_pause_send` and `rx_pause_active` controls consumed by the TX padding/adapter stage.
- TX side: decides when XOFF/XON pause frames are requested, based on RX FIFO fill level with hysteresis, a minimum hold time and a software override.
- RX side: times received pause quanta and throttles the local transmitter.
- Sits between the RX FIFO/pause-frame decoder and the TX adapter, in the `clk` domain.

Parameters:
- LEVEL_W, 12, width of the RX FIFO fill-level input and the thresholds.
- QUANTUM_CYCLES, 8, clk cycles per pause quantum (512 bit times at 64 bits per cycle). Must be a power of two and at least 2.

Ports:
- clk  in  1  MAC core clock.
- aresetn  in  1  asynchronous active-low reset. All state clears immediately on assertion; release is synchronous to clk.
- rx_fifo_level  in  LEVEL_W  current RX FIFO occupancy in words.
- cfg_xoff_thresh  in  LEVEL_W  level at or above which XOFF is requested.
- cfg_xon_thresh  in  LEVEL_W  level at or below which XON is allowed.
- cfg_min_hold  in  16  minimum XOFF duration in clk cycles.
- cfg_tx_pause_enable  in  1  enables TX pause generation.
- cfg_rx_pause_enable  in  1  enables honouring of received pause frames.
- sw_pause_req  in  1  software XOFF request; level-sensitive.
- rx_pause_valid  in  1  one-cycle strobe: a valid pause frame was decoded.
- rx_pause_quanta  in  16  quanta field of that frame.
- tx_pause_send  out  1  XOFF request level to the TX adapter.
- rx_pause_active  out  1  local transmitter must stall.
- rx_pause_remaining  out  16  quanta still outstanding.
- cfg_err  out  1  `cfg_xon_thresh >= cfg_xoff_thresh`.
- stats_clr  in  1  synchronous clear of statistics.
- stat_xoff_events  out  32  count of XON->XOFF transitions.
- stat_rx_pause_frames  out  32  count of accepted RX pause frames.

Behaviour:
- Reset values: every output is 0; the TX FSM is in TX_XON; all counters are 0.

RX quanta timer:
- State: registers `q_cnt[15:0]` and `sub_cnt[log2(QUANTUM_CYCLES)-1:0]`.
- Load: when `rx_pause_valid && cfg_rx_pause_enable`, set `q_cnt <= rx_pause_quanta` and `sub_cnt <= 0`.
  - A frame arriving mid-pause reloads the timer; it does not accumulate.
  - Quanta 0 clears the pause; `rx_pause_active` falls on the next cycle.
- Count: otherwise, while `q_cnt != 0`, increment `sub_cnt` each cycle. When `sub_cnt == QUANTUM_CYCLES-1`, wrap `sub_cnt` to 0 and decrement `q_cnt`.
- Outputs (both registered):
  - `rx_pause_active = (q_cnt != 0)`.
  - `rx_pause_remaining = q_cnt`.
- Latency: a strobe in cycle N gives `rx_pause_active` high from cycle N+1 for exactly `quanta * QUANTUM_CYCLES` cycles.
- Disable: `cfg_rx_pause_enable` low ignores strobes and clears `q_cnt` and `sub_cnt` on the next cycle.

TX scheduler:
- `xoff_cond = sw_pause_req || (rx_fifo_level >= cfg_xoff_thresh)`.
- `xon_cond = !sw_pause_req && (rx_fifo_level <= cfg_xon_thresh)`.
- Misconfiguration: `cfg_err` is registered as `cfg_xon_thresh >= cfg_xoff_thresh`. While `cfg_err` is high, the level-based `xoff_cond` term is masked; `sw_pause_req` still works.

TX FSM states and transitions:
- TX_XON: `tx_pause_send = 0`.
  - If `cfg_tx_pause_enable && xoff_cond`: go to TX_HOLD, load `hold_cnt <= cfg_min_hold`, increment `stat_xoff_events`.
- TX_HOLD: `tx_pause_send = 1`.
  - Decrement `hold_cnt` each cycle.
  - When `hold_cnt == 0`, go to TX_ARMED. `cfg_min_hold = 0` therefore passes through TX_HOLD for 1 cycle.
- TX_ARMED: `tx_pause_send = 1`.
  - If `xon_cond`, go to TX_XON.
- Any state: `cfg_tx_pause_enable` low forces TX_XON on the next cycle; this has priority over all other transitions.
- `tx_pause_send` is registered from the state. It rises 1 cycle after the `xoff_cond` cycle.
- A level dropping below `cfg_xon_thresh` during TX_HOLD does not release early.
- No re-entry to XOFF occurs in the same cycle as an XON exit. Re-evaluation happens from TX_XON on the next cycle.

Statistics:
- 32-bit counters that saturate at 0xFFFFFFFF; no wrap.
- `stats_clr` has priority over a coincident increment: the counter becomes 0.
- `stat_rx_pause_frames` counts accepted strobes only; strobes ignored because `cfg_rx_pause_enable` is low are not counted.

Reset mid-operation:
- Asserting `aresetn` drops `tx_pause_send` and `rx_pause_active` immediately.
- The TX adapter's pause state is not informed by this block.

Optional Feature:
- Macro: PAUSE_FLOW_STATS_EN.
- Defined: both statistics counters are implemented as described above.
- Undefined: no counter flops are built; `stat_xoff_events` and `stat_rx_pause_frames` are tied to 0 and `stats_clr` is ignored.
- All other behaviour is identical in both builds.

Test Plan:
1. Strobe `rx_pause_valid` with quanta=3, rx enabled -> `rx_pause_active` high for exactly 24 cycles starting at N+1; `rx_pause_remaining` steps 3, 2, 1, 0.
2. Quanta=100 strobe, then after 40 cycles a quanta=2 strobe -> timer reloads; active for 16 more cycles; `stat_rx_pause_frames` = 2.
3. xoff=800, xon=200, min_hold=50; level ramps to 800 and then immediately drops to 100 -> `tx_pause_send` high 1 cycle after the crossing and stays high at least 51 cycles; returns to 0 one cycle after leaving TX_ARMED.
4. xon=500, xoff=400 -> `cfg_err` = 1; level at 1000 does not raise `tx_pause_send`; `sw_pause_req` = 1 does raise it.
5. In TX_ARMED, deassert `cfg_tx_pause_enable` -> `tx_pause_send` drops next cycle; assert `aresetn` low mid-pause -> all outputs 0 asynchronously.
6. With PAUSE_FLOW_STATS_EN, preload the counter to 0xFFFFFFFF via repeated events -> it holds saturated; `stats_clr` coincident with an XOFF event -> counter reads 0.
